// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the PE column datapath.
//   PSUM_W  : default partial-sum width (signed two's complement)
//   psum_t  : signed partial-sum type at the default width
//   relu()  : clamps negative sums to zero; used by psum_accumulator when
//             the PSUM_RELU_EN macro is defined
// -----------------------------------------------------------------------------
package pe_pkg;

  localparam int PSUM_W = 32;

  typedef logic signed [PSUM_W-1:0] psum_t;

  function automatic psum_t relu(input psum_t s);
    return (s < 0) ? '0 : s;
  endfunction

endpackage

// File: rtl/psum_fifo.sv
// -----------------------------------------------------------------------------
// psum_fifo
// Synchronous first-word-fall-through FIFO for finished accumulation results.
// The head entry is presented on data_o whenever the FIFO is non-empty; when
// empty, data_o holds the last popped word (0 after reset or clear).
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   clear_i  in   synchronous clear, overrides push and pop
//   push_i   in   write data_i (ignored when full)
//   data_i   in   WIDTH write data
//   pop_i    in   remove head entry (ignored when empty)
//   data_o   out  WIDTH head entry
//   full_o   out  FIFO holds DEPTH entries
//   empty_o  out  FIFO holds no entries
// DEPTH must be a power of two, >= 2.
// -----------------------------------------------------------------------------
module psum_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = empty_o ? last_q : mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else if (clear_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) begin
        rd_q   <= rd_q + 1'b1;
        last_q <= mem_q[rd_q];
      end
      // Simultaneous push and pop leave occupancy unchanged.
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage is data only and needs no reset.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/psum_accumulator.sv
// -----------------------------------------------------------------------------
// psum_accumulator
// Accumulates the PE column's partial-sum stream over PASSES input-channel
// tiles for DEPTH output positions, then pushes each finished sum into an
// output FIFO drained with valid/ready.
// Optional build macro: PSUM_RELU_EN -- when defined, negative finished sums
// are clamped to zero before entering the FIFO (buffer values unaffected).
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   clear         in   synchronous abort of counters and FIFO
//   inValid       in   inPartialSum valid
//   inReady       out  input accepted this cycle if inValid
//   inPartialSum  in   signed partial sum
//   outValid      out  outSum valid
//   outReady      in   consumer accepts outSum
//   outSum        out  finished accumulated sum (FIFO head)
//   entryIdx      out  entry targeted by the next accepted input
//   passIdx       out  current pass
//   busy          out  mid-tile or results pending in the FIFO
// -----------------------------------------------------------------------------
module psum_accumulator
  import pe_pkg::*;
#(
  parameter int accumulationPar = PSUM_W,
  parameter int DEPTH           = 16,
  parameter int PASSES          = 4,
  parameter int FIFO_DEPTH      = 4,
  localparam int EW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic                              inValid,
  output logic                              inReady,
  input  logic signed [accumulationPar-1:0] inPartialSum,
  output logic                              outValid,
  input  logic                              outReady,
  output logic signed [accumulationPar-1:0] outSum,
  output logic [EW-1:0]                     entryIdx,
  output logic [PW-1:0]                     passIdx,
  output logic                              busy
);

  typedef logic signed [accumulationPar-1:0] acc_t;

  localparam logic [EW-1:0] ENTRY_LAST = EW'(DEPTH - 1);
  localparam logic [PW-1:0] PASS_LAST  = PW'(PASSES - 1);

  acc_t          acc_buf_q [DEPTH];
  logic [EW-1:0] entry_q, entry_d;
  logic [PW-1:0] pass_q, pass_d;
  logic          accept;
  logic          last_pass;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  acc_t          base;
  acc_t          sum;
  acc_t          push_data;

  // Final value pushed to the FIFO; clamp is sign-bit driven so it also works
  // when the module width differs from the package default.
  function automatic acc_t result_fn(input acc_t s);
`ifdef PSUM_RELU_EN
    if (accumulationPar == PSUM_W) return acc_t'(relu(psum_t'(s)));
    return s[accumulationPar-1] ? '0 : s;
`else
    return s;
`endif
  endfunction

  assign last_pass = (pass_q == PASS_LAST);
  // Deliberately independent of outReady: a full FIFO stalls the last pass
  // even when a pop happens in the same cycle.
  assign inReady   = !(last_pass && fifo_full);
  assign accept    = inValid && inReady;

  // Pass 0 starts from zero, so it overwrites stale buffer content and, for
  // PASSES==1, the input is pushed unchanged.
  assign base      = (pass_q == '0) ? '0 : acc_buf_q[entry_q];
  assign sum       = base + inPartialSum;
  assign push_data = result_fn(sum);

  assign fifo_push = accept && last_pass && !clear;
  assign fifo_pop  = outValid && outReady;

  always_comb begin
    entry_d = entry_q;
    pass_d  = pass_q;
    if (accept) begin
      if (entry_q == ENTRY_LAST) begin
        entry_d = '0;
        pass_d  = last_pass ? '0 : pass_q + 1'b1;
      end else begin
        entry_d = entry_q + 1'b1;
      end
    end
    if (clear) begin
      entry_d = '0;
      pass_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
      pass_q  <= '0;
    end else begin
      entry_q <= entry_d;
      pass_q  <= pass_d;
    end
  end

  // Last pass reads the buffer but leaves it untouched.
  always_ff @(posedge clk) begin
    if (accept && !last_pass && !clear) acc_buf_q[entry_q] <= sum;
  end

  psum_fifo #(
    .WIDTH (accumulationPar),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear),
    .push_i  (fifo_push),
    .data_i  (push_data),
    .pop_i   (fifo_pop),
    .data_o  (outSum),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign outValid = !fifo_empty;
  assign entryIdx = entry_q;
  assign passIdx  = pass_q;
  assign busy     = (entry_q != '0) || (pass_q != '0) || !fifo_empty;

endmodule
